apb4_decoder_timeout: RTL and testbench
=======================================

APB4_DECODER_TIMEOUT -- requirements
Module: apb4_decoder_timeout

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, data bus width; a multiple of 8.
- ADDR_WIDTH, 32, address width.
- N_CHILD, 4, number of child APB4 ports; range 1..16.
- CHILD_ADDR_BITS, 12, each child occupies one aligned window of 2^CHILD_ADDR_BITS bytes.
- BASE_ADDR, 0, start of the window for child 0; child i window starts at BASE_ADDR + i*2^CHILD_ADDR_BITS.
- TIMEOUT_CYCLES, 256, child ACCESS cycles before abort; 0 disables the timeout.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- PCLK, in, 1, sole clock; all state changes on the rising edge.
- PRESET, in, 1, synchronous active-high reset.
- s_PSEL, s_PENABLE, s_PWRITE, in, 1 each, upstream command.
- s_PPROT, in, 3, upstream protection.
- s_PADDR, in, ADDR_WIDTH, upstream address.
- s_PWDATA, in, DATA_WIDTH, upstream write data.
- s_PSTRB, in, DATA_WIDTH/8, upstream write strobes.
- s_PRDATA, out, DATA_WIDTH, upstream read data.
- s_PREADY, s_PSLVERR, out, 1 each, upstream response.
- m_PSEL, out, N_CHILD, one-hot child select.
- m_PENABLE, m_PWRITE, out, 1 each, broadcast to all children.
- m_PPROT, out, 3, broadcast to all children.
- m_PADDR, out, CHILD_ADDR_BITS, child-relative offset.
- m_PWDATA, out, DATA_WIDTH, broadcast write data.
- m_PSTRB, out, DATA_WIDTH/8, broadcast write strobes.
- m_PRDATA, in, N_CHILD*DATA_WIDTH, child i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- m_PREADY, m_PSLVERR, in, N_CHILD each, child responses.
- timeout_pulse, out, 1, one-cycle strobe when a child times out.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CSETUP, CACCESS, RESP.
REQ-004 In IDLE, on s_PSEL=1 and s_PENABLE=0, the block SHALL register the command fields and a decoded index, then move to:
- CSETUP when the address hits a child window;
- RESP with an error flag when it hits no window.
REQ-005 Decode SHALL be a hit on child i when (s_PADDR - BASE_ADDR) >> CHILD_ADDR_BITS == i, with the subtraction done without wrap: addresses below BASE_ADDR SHALL be unmapped.
REQ-006 m_PADDR SHALL equal the low CHILD_ADDR_BITS of the captured address.
REQ-007 In CSETUP, outputs SHALL be m_PSEL[idx]=1, m_PENABLE=0; the next state SHALL be CACCESS.
REQ-008 In CACCESS, outputs SHALL be m_PSEL[idx]=1, m_PENABLE=1.
- On m_PREADY[idx]=1, the block SHALL capture the m_PRDATA slice and m_PSLVERR[idx], then go to RESP.
REQ-009 A timeout counter SHALL clear on entry to CACCESS and increment each CACCESS cycle while m_PREADY[idx]=0.
- When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES-1 with PREADY still low, the block SHALL pulse timeout_pulse and go to RESP with the error flag set.
- Child select SHALL deassert on the next cycle.
REQ-010 In RESP, with s_PSEL=1 and s_PENABLE=1, the block SHALL drive s_PREADY=1 for exactly one cycle, then go to IDLE.
- s_PRDATA SHALL be the captured data, or 0 on error or write.
- s_PSLVERR SHALL be the captured error flag.
REQ-011 s_PREADY SHALL be 0 in every other state.
- s_PRDATA and s_PSLVERR SHALL be 0 whenever s_PREADY=0.
REQ-012 Minimum upstream latency SHALL be:
- setup at cycle T;
- s_PREADY at T+3 (child PREADY in its first ACCESS cycle).
- Unmapped: s_PREADY at T+1.
REQ-013 If s_PSEL drops during CSETUP or CACCESS, the child transfer SHALL complete or time out normally, the response SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-014 At most one m_PSEL bit SHALL be high at any time; all m_PSEL bits SHALL be 0 in IDLE and RESP.
REQ-015 Broadcast outputs SHALL hold the captured values from CSETUP through CACCESS exit.

Reset
REQ-016 PRESET=1 SHALL force, at the next PCLK edge:
- FSM to IDLE;
- timeout counter to 0;
- every output to 0.
REQ-017 Reset asserted mid-transfer SHALL abandon the transfer, with m_PSEL=0 the following cycle and no s_PREADY.

Verification
REQ-018 Read, child 2 hit, default parameters: PADDR=0x2010, child PREADY at first ACCESS with PRDATA=0xCAFEF00D -> m_PSEL=4'b0100, m_PADDR=0x010, s_PREADY at T+3, s_PRDATA=0xCAFEF00D, s_PSLVERR=0.
REQ-019 Write to unmapped address: PADDR=0x4000 -> no m_PSEL activity, s_PREADY at T+1, s_PSLVERR=1.
REQ-020 Timeout, TIMEOUT_CYCLES=4, child 1 never ready -> exactly 4 CACCESS cycles, timeout_pulse once, s_PSLVERR=1, s_PRDATA=0.
REQ-021 Child wait states: child 3 inserts 5 wait cycles then asserts PSLVERR -> s_PREADY at T+8, s_PSLVERR=1, timeout_pulse stays 0.
REQ-022 Reset in CACCESS, then a new read to child 0 -> all outputs 0 after reset, and the next transfer completes normally.
REQ-023 Back-to-back transfers to children 0 then 1 -> one-hot m_PSEL throughout, and no overlap of child selects.

Source files
------------

// File: rtl/apb4_decoder_timeout.sv
// apb4_decoder_timeout: APB4 one-to-N address decoder with per-transfer child timeout
module apb4_decoder_timeout #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_CHILD = 4,
  parameter int CHILD_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          s_PSEL,
  input  logic                          s_PENABLE,
  input  logic                          s_PWRITE,
  input  logic [2:0]                    s_PPROT,
  input  logic [ADDR_WIDTH-1:0]         s_PADDR,
  input  logic [DATA_WIDTH-1:0]         s_PWDATA,
  input  logic [DATA_WIDTH/8-1:0]       s_PSTRB,
  output logic [DATA_WIDTH-1:0]         s_PRDATA,
  output logic                          s_PREADY,
  output logic                          s_PSLVERR,
  output logic [N_CHILD-1:0]            m_PSEL,
  output logic                          m_PENABLE,
  output logic                          m_PWRITE,
  output logic [2:0]                    m_PPROT,
  output logic [CHILD_ADDR_BITS-1:0]    m_PADDR,
  output logic [DATA_WIDTH-1:0]         m_PWDATA,
  output logic [DATA_WIDTH/8-1:0]       m_PSTRB,
  input  logic [N_CHILD*DATA_WIDTH-1:0] m_PRDATA,
  input  logic [N_CHILD-1:0]            m_PREADY,
  input  logic [N_CHILD-1:0]            m_PSLVERR,
  output logic                          timeout_pulse
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = N_CHILD > 1 ? $clog2(N_CHILD) : 1;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, CSETUP, CACCESS, RESP} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [CHILD_ADDR_BITS-1:0] addr;
  logic wr, err, drop;
  logic [2:0] prot;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [SW-1:0] strb;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] win;
  logic hit, start, act, c_ready, expire, done, reply;
  // Addresses below the base are rejected before the subtraction can wrap
  assign win = (s_PADDR - BASE_ADDR) >> CHILD_ADDR_BITS;
  assign hit = s_PADDR >= BASE_ADDR && win < ADDR_WIDTH'(N_CHILD);
  assign start = state == IDLE && s_PSEL && !s_PENABLE;
  assign act = state == CSETUP || state == CACCESS;
  assign c_ready = m_PREADY[idx];
  assign expire = TIMEOUT_CYCLES != 0 && state == CACCESS && !c_ready && cnt == LAST;
  assign done = state == CACCESS && (c_ready || expire);
  assign reply = state == RESP && s_PSEL && s_PENABLE && !drop;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = hit ? CSETUP : RESP;
      CSETUP:  next = CACCESS;
      CACCESS: if (done) next = RESP;
      RESP:    if (reply || drop || !s_PSEL) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      addr <= '0;
      wr <= 1'b0;
      prot <= '0;
      wdata <= '0;
      strb <= '0;
      err <= 1'b0;
      drop <= 1'b0;
      rdata <= '0;
    end else begin
      state <= next;
      cnt <= state == CACCESS && !c_ready ? cnt + CW'(1) : '0;
      if (start) begin
        idx <= win[IW-1:0];
        addr <= s_PADDR[CHILD_ADDR_BITS-1:0];
        wr <= s_PWRITE;
        prot <= s_PPROT;
        wdata <= s_PWDATA;
        strb <= s_PSTRB;
        err <= !hit;
        drop <= 1'b0;
        rdata <= '0;
      end
      if (act && !s_PSEL) drop <= 1'b1;
      if (done) begin
        rdata <= m_PRDATA[idx*DATA_WIDTH +: DATA_WIDTH];
        err <= expire || m_PSLVERR[idx];
      end
    end
  end
  // Broadcasts are gated to the child phases so IDLE/RESP present an all-zero bus
  assign m_PSEL = act ? N_CHILD'(1) << idx : '0;
  assign m_PENABLE = state == CACCESS;
  assign m_PWRITE = act && wr;
  assign m_PPROT = act ? prot : '0;
  assign m_PADDR = act ? addr : '0;
  assign m_PWDATA = act ? wdata : '0;
  assign m_PSTRB = act ? strb : '0;
  assign s_PREADY = reply;
  assign s_PSLVERR = reply && err;
  assign s_PRDATA = reply && !err && !wr ? rdata : '0;
  assign timeout_pulse = expire;
endmodule

// File: tb/tb_apb4_decoder_timeout.sv
// tb_apb4_decoder_timeout: directed bench; dut_a uses defaults, dut_b has BASE_ADDR=0x1000, TIMEOUT_CYCLES=4
module tb_apb4_decoder_timeout;
  logic PCLK = 0, PRESET = 0;
  logic s_psel = 0, s_penable = 0, s_pwrite = 0;
  logic [2:0] s_pprot = 0;
  logic [31:0] s_paddr = 0, s_pwdata = 0;
  logic [3:0] s_pstrb = 0;
  logic [127:0] m_prdata;
  logic [3:0] err_cfg = 0;
  int wait_cfg [4] = '{0, 0, 0, 0};
  logic [31:0] s_prdata_a, s_prdata_b, m_pwdata_a, m_pwdata_b;
  logic s_pready_a, s_pready_b, s_pslverr_a, s_pslverr_b;
  logic [3:0] m_psel_a, m_psel_b, m_pstrb_a, m_pstrb_b, rdy_a, rdy_b;
  logic m_pen_a, m_pen_b, m_pwrite_a, m_pwrite_b, timeout_a, timeout_b;
  logic [2:0] m_pprot_a, m_pprot_b;
  logic [11:0] m_paddr_a, m_paddr_b;
  int n_checks = 0, n_fail = 0;
  int wc_a = 0, wc_b = 0;
  int onehot_bad_a, overlap_a, sel_cycles_a, access_a, access_b, pulse_a, pulse_b;
  int pready_a, bad_idle_a, bad_idle_b;
  logic [3:0] prev_sel_a, seen_sel_a, seen_strb_a;
  logic [11:0] seen_paddr_a;
  logic [31:0] seen_wdata_a;
  logic [2:0] seen_prot_a;
  logic seen_write_a;

  assign m_prdata = {32'h3333_0003, 32'hCAFE_F00D, 32'h2222_0001, 32'h1111_0000};

  apb4_decoder_timeout dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .s_PSEL(s_psel), .s_PENABLE(s_penable), .s_PWRITE(s_pwrite),
    .s_PPROT(s_pprot), .s_PADDR(s_paddr), .s_PWDATA(s_pwdata), .s_PSTRB(s_pstrb),
    .s_PRDATA(s_prdata_a), .s_PREADY(s_pready_a), .s_PSLVERR(s_pslverr_a),
    .m_PSEL(m_psel_a), .m_PENABLE(m_pen_a), .m_PWRITE(m_pwrite_a), .m_PPROT(m_pprot_a),
    .m_PADDR(m_paddr_a), .m_PWDATA(m_pwdata_a), .m_PSTRB(m_pstrb_a), .m_PRDATA(m_prdata),
    .m_PREADY(rdy_a), .m_PSLVERR(err_cfg), .timeout_pulse(timeout_a));

  apb4_decoder_timeout #(.BASE_ADDR(32'h1000), .TIMEOUT_CYCLES(4)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .s_PSEL(s_psel), .s_PENABLE(s_penable), .s_PWRITE(s_pwrite),
    .s_PPROT(s_pprot), .s_PADDR(s_paddr), .s_PWDATA(s_pwdata), .s_PSTRB(s_pstrb),
    .s_PRDATA(s_prdata_b), .s_PREADY(s_pready_b), .s_PSLVERR(s_pslverr_b),
    .m_PSEL(m_psel_b), .m_PENABLE(m_pen_b), .m_PWRITE(m_pwrite_b), .m_PPROT(m_pprot_b),
    .m_PADDR(m_paddr_b), .m_PWDATA(m_pwdata_b), .m_PSTRB(m_pstrb_b), .m_PRDATA(m_prdata),
    .m_PREADY(rdy_b), .m_PSLVERR(err_cfg), .timeout_pulse(timeout_b));

  always #5 PCLK = ~PCLK;

  // Child models: ready once wait_cfg[i] ACCESS cycles have elapsed
  always_comb begin
    rdy_a = '0;
    for (int i = 0; i < 4; i++) rdy_a[i] = m_psel_a[i] && m_pen_a && wc_a >= wait_cfg[i];
  end
  always_comb begin
    rdy_b = '0;
    for (int i = 0; i < 4; i++) rdy_b[i] = m_psel_b[i] && m_pen_b && wc_b >= wait_cfg[i];
  end
  always @(posedge PCLK) begin
    wc_a <= (|m_psel_a && m_pen_a && !(|(m_psel_a & rdy_a))) ? wc_a + 1 : 0;
    wc_b <= (|m_psel_b && m_pen_b && !(|(m_psel_b & rdy_b))) ? wc_b + 1 : 0;
  end

  always @(negedge PCLK) begin
    if ($countones(m_psel_a) > 1) onehot_bad_a++;
    if (m_psel_a != 0 && prev_sel_a != 0 && m_psel_a != prev_sel_a) overlap_a++;
    prev_sel_a = m_psel_a;
    if (m_psel_a != 0) begin
      sel_cycles_a++;
      seen_sel_a = m_psel_a;
      seen_paddr_a = m_paddr_a;
      seen_wdata_a = m_pwdata_a;
      seen_prot_a = m_pprot_a;
      seen_strb_a = m_pstrb_a;
      seen_write_a = m_pwrite_a;
    end
    if (m_psel_a != 0 && m_pen_a) access_a++;
    if (m_psel_b != 0 && m_pen_b) access_b++;
    if (timeout_a) pulse_a++;
    if (timeout_b) pulse_b++;
    if (s_pready_a) pready_a++;
    if (!s_pready_a && (s_prdata_a != 0 || s_pslverr_a)) bad_idle_a++;
    if (!s_pready_b && (s_prdata_b != 0 || s_pslverr_b)) bad_idle_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    onehot_bad_a = 0; overlap_a = 0; sel_cycles_a = 0; access_a = 0; access_b = 0;
    pulse_a = 0; pulse_b = 0; pready_a = 0; bad_idle_a = 0; bad_idle_b = 0;
    prev_sel_a = 0; seen_sel_a = 0; seen_paddr_a = 0; seen_wdata_a = 0;
    seen_prot_a = 0; seen_strb_a = 0; seen_write_a = 0;
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESET = 1; s_psel = 0; s_penable = 0; s_pwrite = 0;
    @(posedge PCLK); #1;
    PRESET = 0;
    clr();
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    s_psel = 0; s_penable = 0;
  endtask

  // Upstream transfer: setup in cycle T; lat = cycles from T to s_PREADY, -1 if never
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd, input bit use_b,
                      output logic [31:0] rd, output logic er, output int lat);
    @(posedge PCLK); #1;
    s_psel = 1; s_penable = 0; s_pwrite = wr; s_paddr = addr; s_pwdata = wd;
    lat = -1; rd = 'x; er = 'x;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(posedge PCLK); #1;
      s_penable = 1;
      @(negedge PCLK);
      if (use_b ? s_pready_b : s_pready_a) begin
        lat = k;
        rd = use_b ? s_prdata_b : s_prdata_a;
        er = use_b ? s_pslverr_b : s_pslverr_a;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge PCLK); #1;
    PRESET = 1; s_psel = 1; s_penable = 0; s_paddr = 32'h2010;
    for (int c = 0; c < 2; c++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      n_checks++; if ({s_pready_a, s_pslverr_a, s_prdata_a, m_psel_a, m_pen_a, m_pwrite_a, m_pprot_a, m_paddr_a, m_pwdata_a, m_pstrb_a, timeout_a} !== '0) begin n_fail++; $display("FAIL reset_out_a: got nonzero outputs sel=%b rdy=%b expected all 0", m_psel_a, s_pready_a); end
      n_checks++; if ({s_pready_b, s_pslverr_b, s_prdata_b, m_psel_b, m_pen_b, m_pwrite_b, m_pprot_b, m_paddr_b, m_pwdata_b, m_pstrb_b, timeout_b} !== '0) begin n_fail++; $display("FAIL reset_out_b: got nonzero outputs sel=%b rdy=%b expected all 0", m_psel_b, s_pready_b); end
    end
    PRESET = 0; s_psel = 0;
    clr();
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    xfer(32'h2010, 0, 0, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL hit_lat: got %0d expected 3", lat); end
    n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hit_rdata: got %h expected cafef00d", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL hit_err: got %b expected 0", er); end
    n_checks++; if (seen_sel_a !== 4'b0100) begin n_fail++; $display("FAIL hit_psel: got %b expected 0100", seen_sel_a); end
    n_checks++; if (seen_paddr_a !== 12'h010) begin n_fail++; $display("FAIL hit_paddr: got %h expected 010", seen_paddr_a); end
    n_checks++; if (sel_cycles_a !== 2) begin n_fail++; $display("FAIL hit_sel_cycles: got %0d expected 2", sel_cycles_a); end
  endtask

  task automatic test_write_broadcast();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    s_pprot = 3'b101; s_pstrb = 4'b1010;
    xfer(32'h1ABC, 1, 32'hDEAD_BEEF, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_lat: got %0d expected 3", lat); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", rd); end
    n_checks++; if (seen_sel_a !== 4'b0010) begin n_fail++; $display("FAIL wr_psel: got %b expected 0010", seen_sel_a); end
    n_checks++; if ({seen_write_a, seen_prot_a, seen_strb_a, seen_paddr_a, seen_wdata_a} !== {1'b1, 3'b101, 4'b1010, 12'hABC, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wr_bcast: got w=%b prot=%b strb=%b addr=%h data=%h expected 1 101 1010 abc deadbeef", seen_write_a, seen_prot_a, seen_strb_a, seen_paddr_a, seen_wdata_a); end
    s_pprot = 0; s_pstrb = 0;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    xfer(32'h4000, 1, 32'h1234_5678, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmap_lat: got %0d expected 1", lat); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL unmap_err: got %b expected 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmap_rdata: got %h expected 0", rd); end
    n_checks++; if (sel_cycles_a !== 0) begin n_fail++; $display("FAIL unmap_sel: got %0d select cycles expected 0", sel_cycles_a); end
    clr();
    xfer(32'h3FFC, 0, 0, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3 || rd !== 32'h3333_0003) begin n_fail++; $display("FAIL top_edge: got lat=%0d data=%h expected 3 33330003", lat, rd); end
    n_checks++; if (seen_sel_a !== 4'b1000 || seen_paddr_a !== 12'hFFC) begin n_fail++; $display("FAIL top_edge_sel: got %b %h expected 1000 ffc", seen_sel_a, seen_paddr_a); end
    // dut_b: 0x0FFC lies below its base, 0x1004 is its child 0
    do_reset();
    xfer(32'h0FFC, 0, 0, 1, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL below_base: got lat=%0d err=%b expected 1 1", lat, er); end
    n_checks++; if (access_b !== 0) begin n_fail++; $display("FAIL below_base_sel: got %0d access cycles expected 0", access_b); end
    xfer(32'h1004, 0, 0, 1, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3 || rd !== 32'h1111_0000 || er !== 1'b0) begin n_fail++; $display("FAIL base_hit: got lat=%0d data=%h err=%b expected 3 11110000 0", lat, rd, er); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    wait_cfg[1] = 1000;
    xfer(32'h2000, 0, 0, 1, rd, er, lat);
    go_idle();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL to_lat: got %0d expected 6", lat); end
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL to_resp: got err=%b data=%h expected 1 0", er, rd); end
    n_checks++; if (access_b !== 4) begin n_fail++; $display("FAIL to_access: got %0d cycles expected 4", access_b); end
    n_checks++; if (pulse_b !== 1) begin n_fail++; $display("FAIL to_pulse: got %0d pulses expected 1", pulse_b); end
    n_checks++; if (bad_idle_b !== 0) begin n_fail++; $display("FAIL to_idle_resp: got %0d nonzero idle responses expected 0", bad_idle_b); end
    wait_cfg[1] = 0;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    wait_cfg[3] = 5; err_cfg = 4'b1000;
    xfer(32'h3000, 0, 0, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL ws_lat: got %0d expected 8", lat); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL ws_err: got %b expected 1", er); end
    n_checks++; if (pulse_a !== 0) begin n_fail++; $display("FAIL ws_pulse: got %0d expected 0", pulse_a); end
    n_checks++; if (access_a !== 6) begin n_fail++; $display("FAIL ws_access: got %0d cycles expected 6", access_a); end
    wait_cfg[3] = 0; err_cfg = 0;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    wait_cfg[2] = 2;
    @(posedge PCLK); #1;
    s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h2000;
    @(posedge PCLK); #1;
    s_penable = 1;
    @(posedge PCLK); #1;
    s_psel = 0; s_penable = 0;
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    n_checks++; if (pready_a !== 0) begin n_fail++; $display("FAIL abort_pready: got %0d ready cycles expected 0", pready_a); end
    n_checks++; if (access_a !== 3) begin n_fail++; $display("FAIL abort_access: got %0d cycles expected 3", access_a); end
    wait_cfg[2] = 0;
    xfer(32'h2004, 0, 0, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3 || rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL abort_next: got lat=%0d data=%h expected 3 cafef00d", lat, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    do_reset();
    wait_cfg[0] = 1000;
    @(posedge PCLK); #1;
    s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h0000;
    @(posedge PCLK); #1;
    s_penable = 1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    n_checks++; if (m_psel_a !== 4'b0001 || m_pen_a !== 1'b1) begin n_fail++; $display("FAIL mid_access: got sel=%b en=%b expected 0001 1", m_psel_a, m_pen_a); end
    @(posedge PCLK); #1;
    PRESET = 1; s_psel = 0; s_penable = 0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    n_checks++; if ({s_pready_a, s_pslverr_a, s_prdata_a, m_psel_a, m_pen_a, m_pprot_a, m_paddr_a, m_pwdata_a, m_pstrb_a, timeout_a} !== '0) begin n_fail++; $display("FAIL mid_reset_out: got sel=%b en=%b rdy=%b expected all 0", m_psel_a, m_pen_a, s_pready_a); end
    n_checks++; if (pready_a !== 0) begin n_fail++; $display("FAIL mid_reset_pready: got %0d expected 0", pready_a); end
    PRESET = 0;
    wait_cfg[0] = 0;
    xfer(32'h0004, 0, 0, 0, rd, er, lat);
    go_idle();
    n_checks++; if (lat !== 3 || rd !== 32'h1111_0000 || er !== 1'b0) begin n_fail++; $display("FAIL mid_next: got lat=%0d data=%h err=%b expected 3 11110000 0", lat, rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1; logic er0, er1; int lat0, lat1;
    do_reset();
    xfer(32'h0008, 0, 0, 0, rd0, er0, lat0);
    xfer(32'h1008, 0, 0, 0, rd1, er1, lat1);
    go_idle();
    n_checks++; if (lat0 !== 3 || rd0 !== 32'h1111_0000 || er0 !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got lat=%0d data=%h err=%b expected 3 11110000 0", lat0, rd0, er0); end
    n_checks++; if (lat1 !== 3 || rd1 !== 32'h2222_0001 || er1 !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got lat=%0d data=%h err=%b expected 3 22220001 0", lat1, rd1, er1); end
    n_checks++; if (onehot_bad_a !== 0 || overlap_a !== 0) begin n_fail++; $display("FAIL b2b_onehot: got %0d multi-hot %0d overlaps expected 0 0", onehot_bad_a, overlap_a); end
    n_checks++; if (sel_cycles_a !== 4) begin n_fail++; $display("FAIL b2b_sel_cycles: got %0d expected 4", sel_cycles_a); end
    n_checks++; if (bad_idle_a !== 0) begin n_fail++; $display("FAIL b2b_idle_resp: got %0d nonzero idle responses expected 0", bad_idle_a); end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_broadcast();
    test_unmapped();
    test_timeout();
    test_wait_states();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
